// File: rtl/sram_chip_responder_if.sv
// sram_chip_responder_if
//   Controller-to-SRAM address/strobe group.
//   SRAM_ADDR  word address driven by the controller
//   SRAM_WE_N  write strobe, active-low
//   Modports: master (controller side), slave (SRAM device side).
//   The bidirectional SRAM_DQ bus is a plain inout port of the responder so the
//   tristate net resolves at the level that owns both bus drivers.
interface sram_chip_responder_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_WE_N;

  modport master (output SRAM_ADDR, output SRAM_WE_N);
  modport slave  (input  SRAM_ADDR, input  SRAM_WE_N);
endinterface

// File: rtl/sram_chip_responder.sv
// sram_chip_responder
//   Cycle-accurate device end of the SRAM pin interface: a 16-bit word array
//   that captures writes and returns reads after READ_LAT cycles, with a sticky
//   bus-contention flag and saturating transaction counters.
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (array contents are kept)
//   bus          sram_chip_responder_if.slave: SRAM_ADDR, SRAM_WE_N
//   SRAM_DQ      16-bit data bus, driven here only in read mode
//   wr_cnt       write transactions, saturating at 16'hFFFF
//   rd_cnt       read transactions, saturating at 16'hFFFF
//   err_contend  sticky: bus value differed from the value driven here
//   err_wp       sticky: write attempted into the protected region
// Configuration
//   SRAM_RESP_WRPROT_EN  when defined, writes with idx >= WP_BASE are dropped
//                        and flag err_wp; otherwise err_wp is tied 0.
module sram_chip_responder #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned READ_LAT = 0,
  parameter int unsigned WP_BASE  = 'h200
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_chip_responder_if.slave bus,
  inout  wire  [15:0]          SRAM_DQ,
  output logic [15:0]          wr_cnt,
  output logic [15:0]          rd_cnt,
  output logic                 err_contend,
  output logic                 err_wp
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_hi;
  logic              wr_en;

  assign addr           = bus.SRAM_ADDR;
  assign idx            = addr[IDX_W-1:0];
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
  // Only a clean 0 is a write; X/Z on the strobe is treated as read mode.
  assign wr_en = (bus.SRAM_WE_N === 1'b0);

  logic [15:0] mem [DEPTH];

  // Read address path
  logic [IDX_W-1:0] rd_idx;
  logic             rd_vld;

  if (READ_LAT == 0) begin : g_lat0
    assign rd_idx = idx;
    assign rd_vld = 1'b1;
  end else begin : g_pipe
    logic [IDX_W-1:0]    p_idx [READ_LAT];
    logic [READ_LAT-1:0] p_vld;

    // A write cycle enters the pipe as an empty slot; older reads keep draining.
    always_ff @(posedge clk) begin
      if (rst) begin
        p_vld <= '0;
      end else begin
        p_vld[0] <= ~wr_en;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
          p_vld[i] <= p_vld[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      p_idx[0] <= idx;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        p_idx[i] <= p_idx[i-1];
      end
    end

    assign rd_idx = p_idx[READ_LAT-1];
    assign rd_vld = p_vld[READ_LAT-1];
  end

  // Array is read at output time, so a read issued before a write to the same
  // word returns the newer data if the write lands while the read is in flight.
  logic        drive;
  logic [15:0] drv_data;

  assign drv_data = mem[rd_idx];
  assign drive    = ~wr_en & rd_vld & ~rst;
  assign SRAM_DQ  = drive ? drv_data : 'z;

  // Write protection
  logic wp_hit;

`ifdef SRAM_RESP_WRPROT_EN
  assign wp_hit = (32'(idx) >= WP_BASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_wp <= 1'b0;
    end else if (wr_en && wp_hit) begin
      err_wp <= 1'b1;
    end
  end
`else
  logic [31:0] unused_wp_base;

  assign unused_wp_base = WP_BASE;
  assign wp_hit         = 1'b0;
  assign err_wp         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst && wr_en && !wp_hit) begin
      mem[idx] <= SRAM_DQ;
    end
  end

  // Transaction counting and contention
  logic             prev_vld;
  logic             prev_wr;
  logic [IDX_W-1:0] prev_idx;
  logic             wr_new;
  logic             rd_new;

  // prev_vld=0 after reset makes the first access of either kind count as new.
  assign wr_new =  wr_en && (!prev_vld || !prev_wr || (prev_idx != idx));
  assign rd_new = !wr_en && (!prev_vld ||  prev_wr || (prev_idx != idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      err_contend <= 1'b0;
      prev_vld    <= 1'b0;
      prev_wr     <= 1'b0;
      prev_idx    <= '0;
    end else begin
      if (wr_new && (wr_cnt != '1)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (rd_new && (rd_cnt != '1)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (drive && (SRAM_DQ !== drv_data)) begin
        err_contend <= 1'b1;
      end
      prev_vld <= 1'b1;
      prev_wr  <= wr_en;
      prev_idx <= idx;
    end
  end
endmodule
